// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, owners,
// memory size codes and the DMA legality check.
package dmem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Size/sign codes understood by the data memory.
  localparam logic [3:0] SM_BYTE   = 4'b0000;
  localparam logic [3:0] SM_HALF   = 4'b0001;
  localparam logic [3:0] SM_WORD   = 4'b0010;
  localparam logic [3:0] SM_BYTE_U = 4'b0100;
  localparam logic [3:0] SM_HALF_U = 4'b0101;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sign_mask;
  } cmd_t;

  function automatic logic dma_addr_ok(input logic [31:0] addr,
                                       input logic [3:0]  sign_mask,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
    logic in_range, misaligned;
    in_range   = (addr >= lo) && (addr < hi);
    misaligned = (sign_mask == SM_WORD) && (addr[1:0] != 2'b00);
    return in_range && !misaligned;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// CPU-priority picker; a saturating count of CPU wins over a waiting DMA
// forces one DMA win so the secondary port cannot starve.
module dmem_rr_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en_i,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  output logic gnt_valid_o,
  output logic gnt_dma_o
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  always_comb begin
    gnt_valid_o = arb_en_i & (cpu_req_i | dma_req_i);
    gnt_dma_o   = arb_en_i & dma_req_i & (~cpu_req_i | (starve_cnt == LIM));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                                        starve_cnt <= '0;
    else if (!dma_req_i)                              starve_cnt <= '0;
    else if (gnt_valid_o && gnt_dma_o)                starve_cnt <= '0;
    else if (gnt_valid_o && (starve_cnt != LIM))      starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the CPU load/store stage and a DMA/debug master onto the
// single-ported, stall-handshaked data memory.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int          STARVE_LIMIT = 4,
  parameter int          BUSY_TIMEOUT = 8,
  parameter logic [31:0] DMA_ADDR_LO  = 32'h1000,
  parameter logic [31:0] DMA_ADDR_HI  = 32'h2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_sign_mask_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [3:0]  dma_sign_mask_i,
  output logic        dma_gnt_o,
  output logic        dma_done_o,
  output logic        dma_err_o,
  output logic [31:0] dma_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_w_ena_o,
  output logic        mem_r_ena_o,
  output logic [3:0]  mem_sign_mask_o,
  input  logic [31:0] mem_r_data_i,
  input  logic        mem_stall_i
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

  state_e        state;
  owner_e        owner;
  logic          cmd_we;
  logic          cpu_done;
  logic [TW-1:0] tcnt;
  logic          dma_req_eff;
  logic          gnt_valid, gnt_dma;
  cmd_t          win;

  assign cpu_stall_o = cpu_req_i & ~cpu_done & ~rst_i;
  // The DMA still holds its request during its own done cycle; hide it so
  // a range-error completion is not immediately re-granted.
  assign dma_req_eff = dma_req_i & ~dma_done_o;

  dmem_rr_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .arb_en_i    (state == IDLE),
    .cpu_req_i   (cpu_req_i),
    .dma_req_i   (dma_req_eff),
    .gnt_valid_o (gnt_valid),
    .gnt_dma_o   (gnt_dma)
  );

  always_comb begin
    win = gnt_dma ? cmd_t'{dma_we_i, dma_addr_i, dma_wdata_i, dma_sign_mask_i}
                  : cmd_t'{cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_sign_mask_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      owner           <= OWN_CPU;
      cmd_we          <= 1'b0;
      cpu_done        <= 1'b0;
      tcnt            <= '0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
      mem_sign_mask_o <= '0;
      mem_r_ena_o     <= 1'b0;
      mem_w_ena_o     <= 1'b0;
      cpu_rdata_o     <= '0;
      dma_rdata_o     <= '0;
      dma_gnt_o       <= 1'b0;
      dma_done_o      <= 1'b0;
      dma_err_o       <= 1'b0;
    end else begin
      mem_r_ena_o <= 1'b0;
      mem_w_ena_o <= 1'b0;
      dma_gnt_o   <= 1'b0;
      dma_done_o  <= 1'b0;
      dma_err_o   <= 1'b0;
      cpu_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner     <= gnt_dma ? OWN_DMA : OWN_CPU;
            dma_gnt_o <= gnt_dma;
            if (gnt_dma && !dma_addr_ok(dma_addr_i, dma_sign_mask_i, DMA_ADDR_LO, DMA_ADDR_HI)) begin
              dma_done_o <= 1'b1;
              dma_err_o  <= 1'b1;
            end else begin
              cmd_we          <= win.we;
              mem_addr_o      <= win.addr;
              mem_wdata_o     <= win.wdata;
              mem_sign_mask_o <= win.sign_mask;
              mem_r_ena_o     <= ~win.we;
              mem_w_ena_o     <= win.we;
              state           <= ISSUE;
            end
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (mem_stall_i) begin
            state <= WAIT_DONE;
          end else if (tcnt == TO_LAST) begin
            state <= RESP;
            if (owner == OWN_DMA) begin
              dma_done_o <= 1'b1;
              dma_err_o  <= 1'b1;
            end else begin
              cpu_done <= 1'b1;
              if (!cmd_we) cpu_rdata_o <= '0;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!mem_stall_i) begin
            state <= RESP;
            if (owner == OWN_DMA) begin
              dma_done_o <= 1'b1;
              if (!cmd_we) dma_rdata_o <= mem_r_data_i;
            end else begin
              cpu_done <= 1'b1;
              if (!cmd_we) cpu_rdata_o <= mem_r_data_i;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small stall-handshake memory model.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_sm, dma_sm;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_done, dma_err, mem_w_ena, mem_r_ena, mem_stall;
  logic [3:0]  mem_sm;

  dmem_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_sign_mask_i(cpu_sm),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_sign_mask_i(dma_sm),
    .dma_gnt_o(dma_gnt), .dma_done_o(dma_done), .dma_err_o(dma_err),
    .dma_rdata_o(dma_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_w_ena_o(mem_w_ena),
    .mem_r_ena_o(mem_r_ena), .mem_sign_mask_o(mem_sm),
    .mem_r_data_i(mem_rdata), .mem_stall_i(mem_stall)
  );

  // Memory: stall rises the cycle after a strobe, stays up two cycles,
  // read data valid when it falls. no_stall models a dead memory.
  logic [1:0]  mcnt;
  logic        no_stall;
  logic [31:0] mem_val;
  assign mem_stall = (mcnt != 2'd0);
  assign mem_rdata = mem_val;
  always @(posedge clk) begin
    if (rst)                        mcnt <= 2'd0;
    else if (mem_r_ena | mem_w_ena) mcnt <= no_stall ? 2'd0 : 2'd2;
    else if (mcnt != 2'd0)          mcnt <= mcnt - 2'd1;
  end

  int nr = 0, nw = 0, ngnt = 0, ndma_evt = 0;
  logic [31:0] last_addr, last_wdata;
  logic [31:0] addr_q[$];
  always @(negedge clk) begin
    if (mem_r_ena) nr++;
    if (mem_w_ena) nw++;
    if (mem_r_ena | mem_w_ena) begin
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
      addr_q.push_back(mem_addr);
    end
    if (dma_gnt) ngnt++;
    if (dma_gnt | dma_done | dma_err) ndma_evt++;
  end

  int ncmp = 0, nerr = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Counts stall cycles of the current CPU access; returns at the done cycle's negedge.
  task automatic wait_cpu(input string tag, output int ncyc);
    logic ok;
    ok = 1'b0; ncyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin ok = 1'b1; break; end
      ncyc++;
    end
    chk({tag, "_no_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  // Cycles from request to dma_done; returns at the done cycle's negedge.
  task automatic wait_dma(input string tag, output int ncyc);
    logic ok;
    ok = 1'b0; ncyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dma_done) begin ok = 1'b1; break; end
      ncyc++;
    end
    chk({tag, "_no_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  int n, nr0, nw0, ev0, g0, base;
  logic dn;

  initial begin
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_sm = SM_WORD;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_sm = SM_WORD;
    no_stall = 1'b0; mem_val = 32'h0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_strobes", {30'd0, mem_r_ena, mem_w_ena}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_dma_out", {29'd0, dma_gnt, dma_done, dma_err}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    tick(); rst = 1'b0;
    tick();

    // CPU load alone
    mem_val = 32'hDEADBEEF; nr0 = nr; nw0 = nw;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1004;
    wait_cpu("ld", n);
    chk("ld_stall_cycles", n, 32'd5);
    chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("ld_r_pulses", nr - nr0, 32'd1);
    chk("ld_addr", last_addr, 32'h1004);
    tick(); cpu_req = 0;
    tick();

    // CPU store
    nr0 = nr; nw0 = nw; ev0 = ndma_evt;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h1008; cpu_wdata = 32'h12345678;
    wait_cpu("st", n);
    chk("st_stall_cycles", n, 32'd5);
    chk("st_w_pulses", nw - nw0, 32'd1);
    chk("st_r_pulses", nr - nr0, 32'd0);
    chk("st_addr", last_addr, 32'h1008);
    chk("st_wdata", last_wdata, 32'h12345678);
    chk("st_no_dma", ndma_evt - ev0, 32'd0);
    chk("st_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    tick(); cpu_req = 0; cpu_we = 0;
    tick();

    // Contention with CPU held: 4 CPU, 1 DMA, then CPU again
    mem_val = 32'hCAFEF00D; base = addr_q.size(); g0 = ngnt;
    cpu_req = 1; cpu_addr = 32'h1010;
    dma_req = 1; dma_we = 0; dma_addr = 32'h1800; dma_sm = SM_WORD;
    for (int i = 0; i < 400 && addr_q.size() < base + 6; i++) begin
      @(negedge clk); dn = dma_done;
      @(posedge clk); #1;
      if (dn) dma_req = 0;
    end
    chk("arb_count", addr_q.size() - base, 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("arb_order%0d", i), addr_q[base + i], (i == 4) ? 32'h1800 : 32'h1010);
    chk("arb_gnt_pulses", ngnt - g0, 32'd1);
    chk("arb_dma_rdata", dma_rdata, 32'hCAFEF00D);
    wait_cpu("arb_tail", n);
    tick(); cpu_req = 0;
    tick();

    // DMA below the legal window: error, no memory access
    nr0 = nr; nw0 = nw;
    dma_req = 1; dma_addr = 32'h0FFC;
    @(negedge clk);
    chk("rng_done_early", {31'd0, dma_done}, 32'd0);
    @(negedge clk);
    chk("rng_done_err", {30'd0, dma_done, dma_err}, 32'd3);
    chk("rng_gnt", {31'd0, dma_gnt}, 32'd1);
    tick(); dma_req = 0;
    tick();
    chk("rng_no_strobe", (nr - nr0) + (nw - nw0), 32'd0);

    // Misaligned word access is also an error
    dma_req = 1; dma_addr = 32'h1002;
    wait_dma("mis", n);
    chk("mis_latency", n, 32'd1);
    chk("mis_err", {31'd0, dma_err}, 32'd1);
    tick(); dma_req = 0;
    tick();

    // Dead memory: busy timeout
    no_stall = 1'b1;
    dma_req = 1; dma_addr = 32'h1100;
    wait_dma("to", n);
    chk("to_latency", n, 32'd10);
    chk("to_err", {31'd0, dma_err}, 32'd1);
    tick(); dma_req = 0; no_stall = 1'b0;
    tick();

    // Next DMA served normally
    mem_val = 32'h55AA55AA;
    dma_req = 1; dma_addr = 32'h1104;
    wait_dma("dok", n);
    chk("dok_latency", n, 32'd5);
    chk("dok_err", {31'd0, dma_err}, 32'd0);
    chk("dok_rdata", dma_rdata, 32'h55AA55AA);
    tick(); dma_req = 0;
    tick();

    // Reset in WAIT_DONE abandons the access
    ev0 = ndma_evt;
    cpu_req = 1; cpu_addr = 32'h1200;
    repeat (3) tick();
    chk("rst_mid_busy", {31'd0, mem_stall}, 32'd1);
    rst = 1'b1; cpu_req = 0;
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    @(negedge clk);
    chk("rst_mid_rdata", cpu_rdata, 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_ctl", {26'd0, mem_r_ena, mem_w_ena, dma_gnt, dma_done, dma_err, cpu_stall}, 32'd0);
    tick(); rst = 1'b0;
    repeat (3) tick();
    chk("rst_mid_no_done", ndma_evt - ev0, 32'd0);
    chk("rst_mid_rdata_hold", cpu_rdata, 32'd0);

    mem_val = 32'h0BADCAFE;
    cpu_req = 1; cpu_addr = 32'h1204;
    wait_cpu("post", n);
    chk("post_stall_cycles", n, 32'd5);
    chk("post_rdata", cpu_rdata, 32'h0BADCAFE);
    tick(); cpu_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sits between the core's load/store stage plus a secondary DMA/debug master and the single-ported, multi-cycle data memory.
- Picks one requester per transaction and drives the memory's one-cycle command strobe.
- Tracks the memory's stall-based busy signal, returns read data to the winner and stalls the CPU while it waits.
- CPU has priority; a starvation counter guarantees the DMA port forward progress.

Parameters:
- STARVE_LIMIT, 4: consecutive CPU grants allowed while a DMA request is pending; then DMA wins once.
- BUSY_TIMEOUT, 8: cycles to wait for mem_stall_i to rise after issue before abort.
- DMA_ADDR_LO, 32'h1000: lowest legal DMA byte address (inclusive).
- DMA_ADDR_HI, 32'h2000: DMA byte-address upper bound (exclusive).

Ports:
- clk_i in 1: clock, all logic on posedge.
- rst_i in 1: reset; synchronous, active-high.
- cpu_req_i in 1: CPU access request, held until cpu_stall_o low.
- cpu_we_i in 1: 1 = store, 0 = load.
- cpu_addr_i in 32: byte address.
- cpu_wdata_i in 32: store data.
- cpu_sign_mask_i in 4: size/sign code, passed through unchanged.
- cpu_rdata_o out 32: load result, registered.
- cpu_stall_o out 1: hold the pipeline.
- dma_req_i in 1: DMA request, held until dma_done_o.
- dma_we_i in 1: DMA write.
- dma_addr_i in 32: DMA address.
- dma_wdata_i in 32: DMA write data.
- dma_sign_mask_i in 4: DMA size code.
- dma_gnt_o out 1: one-cycle pulse when DMA wins arbitration.
- dma_done_o out 1: one-cycle completion pulse.
- dma_err_o out 1: qualifies dma_done_o (range error or timeout).
- dma_rdata_o out 32: DMA read data, registered.
- mem_addr_o out 32: memory address.
- mem_wdata_o out 32: memory write data.
- mem_w_ena_o out 1: memory write strobe.
- mem_r_ena_o out 1: memory read strobe.
- mem_sign_mask_o out 4: memory size code.
- mem_r_data_i in 32: memory read data.
- mem_stall_i in 1: memory busy.

Behaviour:
- Reset (sync, rst_i high at posedge):
  - State IDLE; all mem_* outputs, rdata regs, dma_gnt_o/dma_done_o/dma_err_o cleared to 0.
  - Starvation and timeout counters cleared to 0; owner = CPU.
  - Reset mid-transaction abandons it with no done pulse. Requesters must re-request.
- cpu_stall_o = cpu_req_i & ~cpu_done, where cpu_done is an internal registered one-cycle pulse. Combinational; 0 during reset.
- States:
  - IDLE:
    - Arbitrate among pending requests. Winner is DMA if dma_req_i and (~cpu_req_i or starve_cnt == STARVE_LIMIT); otherwise CPU.
    - Latch the winner's addr/wdata/we/sign_mask into command regs, record owner, go ISSUE.
    - DMA winner pulses dma_gnt_o.
    - DMA address outside [DMA_ADDR_LO, DMA_ADDR_HI), or not word-aligned for a word access: no memory access; dma_done_o = dma_err_o = 1 next cycle; stay IDLE.
  - ISSUE: drive mem_r_ena_o (load) or mem_w_ena_o (store) high for exactly this one cycle; mem_addr_o/wdata/sign_mask valid. Go WAIT_BUSY.
  - WAIT_BUSY:
    - Strobes low; address/data held stable.
    - mem_stall_i high: go WAIT_DONE.
    - Timeout counter reaches BUSY_TIMEOUT: go RESP with error. For a CPU owner, rdata = 0 and no error output (CPU path has none).
  - WAIT_DONE: mem_stall_i low: capture mem_r_data_i (valid on the same cycle stall falls) into the owner's rdata reg on loads. Go RESP.
  - RESP: one-cycle pulse of cpu_done or dma_done_o (plus dma_err_o on timeout); go IDLE.
- Latency: minimum IDLE→RESP is 5 cycles with the current 3-cycle memory. The CPU sees stall for 5 cycles per access.
- Starvation counter:
  - Increments on each CPU grant while dma_req_i is high; saturates at STARVE_LIMIT.
  - Clears on a DMA grant, or when dma_req_i is low.
- Simultaneous first requests: CPU wins.
- Back-to-back: a new arbitration occurs in IDLE the cycle after RESP. There is no idle bubble beyond that.
- A requester deasserting early is ignored once it has won; the command regs are already latched.
- Stores do not alter rdata regs.

Decomposition:
- Shared package/include: state encodings (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP), owner encodings (OWN_CPU, OWN_DMA), and the sign_mask size codes already used by the memory.
- One natural sub-module, dmem_rr_pick: a combinational priority/starvation picker with its saturating counter. Everything else stays in the top level.

Test Plan:
- CPU load 0x1004 alone, memory returns 0xDEADBEEF → one mem_r_ena_o pulse; cpu_stall_o high for 5 cycles; cpu_rdata_o = 0xDEADBEEF.
- CPU store 0x1008 = 0x12345678 → single mem_w_ena_o cycle with that addr/data; no DMA outputs toggle.
- CPU and DMA request together, CPU held continuously → grants CPU×4, then DMA (dma_gnt_o pulse), then CPU; counter returns to 0.
- DMA read 0x0FFC (below DMA_ADDR_LO) → no memory strobe; dma_done_o = dma_err_o = 1 two cycles after request.
- Memory model never raises stall → after 8 cycles in WAIT_BUSY, dma_done_o with dma_err_o = 1; next request is served normally.
- rst_i asserted during WAIT_DONE → all outputs 0 next cycle; no done pulse; a following CPU load completes correctly.
